// File: rtl/wbcon_pkg.sv
// Shared definitions for the wbcon Wishbone-to-CSR responder.
//   state_t       : responder FSM states
//   resp_code_t   : which Wishbone strobe (if any) the RESP state drives
package wbcon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CSR_WAIT = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  typedef logic [1:0] resp_code_t;

  localparam resp_code_t RESP_NONE = 2'd0;
  localparam resp_code_t RESP_ACK  = 2'd1;
  localparam resp_code_t RESP_ERR  = 2'd2;
  localparam resp_code_t RESP_RTY  = 2'd3;

endpackage

// File: rtl/wbcon_csr_target.sv
// Wishbone B4 pipelined slave that terminates one transfer at a time and turns it
// into a req/done access on a simple CSR register port. Out-of-range addresses and
// CSR logic that never answers both end in ERR so the master cannot hang.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_wb_cyc/stb/we/adr/dat/sel  Wishbone request
//   o_wb_stall/ack/err/rty/dat   Wishbone response (stall is combinational)
//   o_csr_req/we/addr/wdata/wmask CSR request, held stable until done
//   i_csr_done/rdata/err/rty     CSR completion, sampled only while o_csr_req=1
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a transfer, stall low
// CSR_WAIT | CSR request outstanding, waiting for done or timeout
// RESP     | one-cycle Wishbone strobe (suppressed if the cycle was aborted)
module wbcon_csr_target
  import wbcon_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 24,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = (WB_DATA_WIDTH + 7) / 8,
  parameter int CSR_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wb_cyc,
  input  logic                      i_wb_stb,
  output logic                      o_wb_stall,
  output logic                      o_wb_ack,
  output logic                      o_wb_err,
  output logic                      o_wb_rty,
  input  logic                      i_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0]  i_wb_adr,
  input  logic [WB_DATA_WIDTH-1:0]  i_wb_dat,
  input  logic [WB_SEL_WIDTH-1:0]   i_wb_sel,
  output logic [WB_DATA_WIDTH-1:0]  o_wb_dat,
  output logic                      o_csr_req,
  output logic                      o_csr_we,
  output logic [CSR_ADDR_WIDTH-1:0] o_csr_addr,
  output logic [WB_DATA_WIDTH-1:0]  o_csr_wdata,
  output logic [WB_SEL_WIDTH-1:0]   o_csr_wmask,
  input  logic                      i_csr_done,
  input  logic [WB_DATA_WIDTH-1:0]  i_csr_rdata,
  input  logic                      i_csr_err,
  input  logic                      i_csr_rty
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      abort_q, abort_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic                      rty_q, rty_d;
  logic [WB_DATA_WIDTH-1:0]  dat_q, dat_d;
  logic                      req_q, req_d;
  logic                      we_q, we_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WB_DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [WB_SEL_WIDTH-1:0]   wmask_q, wmask_d;

  resp_code_t resp_code;
  logic       abort_now;
  logic       addr_hi_nz;

  assign addr_hi_nz = |i_wb_adr[WB_ADDR_WIDTH-1:CSR_ADDR_WIDTH];
  assign abort_now  = abort_q | ~i_wb_cyc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    dat_d     = dat_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    resp_code = RESP_NONE;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        cnt_d   = '0;
        if (i_wb_cyc && i_wb_stb) begin
          we_d    = i_wb_we;
          addr_d  = i_wb_adr[CSR_ADDR_WIDTH-1:0];
          wdata_d = i_wb_dat;
          wmask_d = i_wb_we ? i_wb_sel : '0;
          if (addr_hi_nz) begin
            state_d   = ST_RESP;
            resp_code = RESP_ERR;
            if (!i_wb_we) dat_d = '0;
          end else if (i_wb_sel == '0) begin
            // Nothing to access: complete immediately, read data left untouched.
            state_d   = ST_RESP;
            resp_code = RESP_ACK;
          end else begin
            state_d = ST_CSR_WAIT;
            req_d   = 1'b1;
          end
        end
      end

      ST_CSR_WAIT: begin
        abort_d = abort_now;
        if (i_csr_done) begin
          // done in the expiry cycle lands here, so it beats the timeout
          req_d   = 1'b0;
          state_d = ST_RESP;
          if (i_csr_err) begin
            resp_code = RESP_ERR;
            if (!we_q) dat_d = '0;
          end else if (i_csr_rty) begin
            resp_code = RESP_RTY;
            if (!we_q) dat_d = '0;
          end else begin
            resp_code = RESP_ACK;
            if (!we_q) dat_d = i_csr_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            req_d     = 1'b0;
            state_d   = ST_RESP;
            resp_code = RESP_ERR;
            if (!we_q) dat_d = '0;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        abort_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        abort_d = 1'b0;
      end
    endcase

    // An aborted cycle still finishes its CSR access but never drives a strobe.
    if (state_q == ST_CSR_WAIT && abort_now) resp_code = RESP_NONE;

    ack_d = (resp_code == RESP_ACK);
    err_d = (resp_code == RESP_ERR);
    rty_d = (resp_code == RESP_RTY);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      dat_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      dat_q   <= dat_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign o_wb_stall  = (state_q != ST_IDLE);
  assign o_wb_ack    = ack_q;
  assign o_wb_err    = err_q;
  assign o_wb_rty    = rty_q;
  assign o_wb_dat    = dat_q;
  assign o_csr_req   = req_q;
  assign o_csr_we    = we_q;
  assign o_csr_addr  = addr_q;
  assign o_csr_wdata = wdata_q;
  assign o_csr_wmask = wmask_q;

endmodule

// File: tb/tb_wbcon_csr_target.sv
module tb_wbcon_csr_target;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [23:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        o_wb_stall, o_wb_ack, o_wb_err, o_wb_rty;
  logic [31:0] o_wb_dat;
  logic        o_csr_req, o_csr_we;
  logic [7:0]  o_csr_addr;
  logic [31:0] o_csr_wdata;
  logic [3:0]  o_csr_wmask;
  logic        i_csr_done, i_csr_err, i_csr_rty;
  logic [31:0] i_csr_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 i_clk = ~i_clk;

  wbcon_csr_target dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_rty(o_wb_rty),
    .i_wb_we(i_wb_we), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .o_wb_dat(o_wb_dat),
    .o_csr_req(o_csr_req), .o_csr_we(o_csr_we), .o_csr_addr(o_csr_addr),
    .o_csr_wdata(o_csr_wdata), .o_csr_wmask(o_csr_wmask),
    .i_csr_done(i_csr_done), .i_csr_rdata(i_csr_rdata),
    .i_csr_err(i_csr_err), .i_csr_rty(i_csr_rty)
  );

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // present one request, let it be accepted, return in the cycle after the accept edge
  task automatic start_xfer(input logic we, input logic [23:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we  = we;
    i_wb_adr = adr;
    i_wb_dat = dat;
    i_wb_sel = sel;
    tick();
    i_wb_stb = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0;
    i_csr_done = 0; i_csr_err = 0; i_csr_rty = 0; i_csr_rdata = '0;
    tick(); tick();
    i_rst = 1'b0;
    n_total++;
    if ({o_wb_stall, o_wb_ack, o_wb_err, o_wb_rty, o_csr_req, o_csr_we} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
               {o_wb_stall, o_wb_ack, o_wb_err, o_wb_rty, o_csr_req, o_csr_we});
    else n_pass++;
    n_total++;
    if ({o_wb_dat, o_csr_addr, o_csr_wdata, o_csr_wmask} !== 76'b0)
      $display("FAIL reset_data: dat=%h addr=%h wdata=%h wmask=%h want all 0",
               o_wb_dat, o_csr_addr, o_csr_wdata, o_csr_wmask);
    else n_pass++;
  endtask

  task automatic test_write_ack();
    start_xfer(1'b1, 24'h000012, 32'hDEADBEEF, 4'hF);
    n_total++;
    if ({o_csr_req, o_csr_we, o_csr_addr, o_csr_wdata, o_csr_wmask, o_wb_stall}
        !== {1'b1, 1'b1, 8'h12, 32'hDEADBEEF, 4'hF, 1'b1})
      $display("FAIL wr_req: req=%b we=%b addr=%h wdata=%h wmask=%h stall=%b want 1 1 12 deadbeef f 1",
               o_csr_req, o_csr_we, o_csr_addr, o_csr_wdata, o_csr_wmask, o_wb_stall);
    else n_pass++;
    i_csr_done = 1'b1;
    tick();
    i_csr_done = 1'b0;
    n_total++;
    if ({o_wb_ack, o_wb_err, o_wb_rty, o_csr_req} !== 4'b1000)
      $display("FAIL wr_ack: ack/err/rty/req=%b want 1000", {o_wb_ack, o_wb_err, o_wb_rty, o_csr_req});
    else n_pass++;
    tick();
    n_total++;
    if ({o_wb_ack, o_wb_stall} !== 2'b00)
      $display("FAIL wr_ack_once: ack/stall=%b want 00", {o_wb_ack, o_wb_stall});
    else n_pass++;
  endtask

  task automatic test_read_ack();
    logic stall_all = 1'b1;
    logic req_all   = 1'b1;
    start_xfer(1'b0, 24'h000034, 32'h0, 4'hF);
    n_total++;
    if ({o_csr_we, o_csr_wmask, o_csr_addr} !== {1'b0, 4'h0, 8'h34})
      $display("FAIL rd_req: we=%b wmask=%h addr=%h want 0 0 34", o_csr_we, o_csr_wmask, o_csr_addr);
    else n_pass++;
    for (int c = 1; c <= 5; c++) begin
      stall_all &= o_wb_stall;
      req_all   &= o_csr_req;
      tick();
    end
    i_csr_done  = 1'b1;
    i_csr_rdata = 32'h12345678;
    stall_all &= o_wb_stall;
    tick();
    i_csr_done  = 1'b0;
    i_csr_rdata = '0;
    stall_all &= o_wb_stall;
    n_total++;
    if ({stall_all, req_all} !== 2'b11)
      $display("FAIL rd_stall_req: stall_all=%b req_all=%b want 1 1", stall_all, req_all);
    else n_pass++;
    n_total++;
    if ({o_wb_ack, o_wb_dat} !== {1'b1, 32'h12345678})
      $display("FAIL rd_ack_data: ack=%b dat=%h want 1 12345678", o_wb_ack, o_wb_dat);
    else n_pass++;
    tick();
    n_total++;
    if (o_wb_stall !== 1'b0)
      $display("FAIL rd_idle: stall=%b want 0", o_wb_stall);
    else n_pass++;
  endtask

  task automatic test_decode_err();
    start_xfer(1'b0, 24'h000100, 32'h0, 4'hF);
    n_total++;
    if ({o_wb_err, o_wb_ack, o_csr_req, o_wb_dat} !== {3'b100, 32'h0})
      $display("FAIL dec_err: err/ack/req=%b dat=%h want 100 0",
               {o_wb_err, o_wb_ack, o_csr_req}, o_wb_dat);
    else n_pass++;
    tick();
    // zero byte selects: immediate ack, no CSR access
    start_xfer(1'b1, 24'h000010, 32'h1, 4'h0);
    n_total++;
    if ({o_wb_ack, o_wb_err, o_csr_req} !== 3'b100)
      $display("FAIL sel0_ack: ack/err/req=%b want 100", {o_wb_ack, o_wb_err, o_csr_req});
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    start_xfer(1'b1, 24'h000020, 32'h55AA55AA, 4'h3);
    while (o_csr_req === 1'b1 && cnt < 400) begin
      cnt++;
      tick();
    end
    n_total++;
    if (cnt !== 255)
      $display("FAIL to_req_len: req cycles=%0d want 255", cnt);
    else n_pass++;
    n_total++;
    if ({o_wb_err, o_wb_ack} !== 2'b10)
      $display("FAIL to_err: err/ack=%b want 10", {o_wb_err, o_wb_ack});
    else n_pass++;
    tick();
    start_xfer(1'b1, 24'h000020, 32'h1, 4'h1);
    i_csr_done = 1'b1;
    tick();
    i_csr_done = 1'b0;
    n_total++;
    if ({o_wb_ack, o_wb_err} !== 2'b10)
      $display("FAIL to_recover: ack/err=%b want 10", {o_wb_ack, o_wb_err});
    else n_pass++;
    tick();
  endtask

  task automatic test_priority();
    start_xfer(1'b1, 24'h000001, 32'h1, 4'hF);
    i_csr_done = 1'b1; i_csr_err = 1'b1; i_csr_rty = 1'b1;
    tick();
    i_csr_done = 1'b0; i_csr_err = 1'b0; i_csr_rty = 1'b0;
    n_total++;
    if ({o_wb_ack, o_wb_err, o_wb_rty} !== 3'b010)
      $display("FAIL err_over_rty: ack/err/rty=%b want 010", {o_wb_ack, o_wb_err, o_wb_rty});
    else n_pass++;
    tick();
    // load nonzero read data, then a read retry must clear it
    start_xfer(1'b0, 24'h000002, 32'h0, 4'hF);
    i_csr_done = 1'b1; i_csr_rdata = 32'hA5A5A5A5;
    tick();
    i_csr_done = 1'b0; i_csr_rdata = '0;
    tick();
    start_xfer(1'b0, 24'h000003, 32'h0, 4'hF);
    i_csr_done = 1'b1; i_csr_rty = 1'b1; i_csr_rdata = 32'hFFFFFFFF;
    tick();
    i_csr_done = 1'b0; i_csr_rty = 1'b0; i_csr_rdata = '0;
    n_total++;
    if ({o_wb_ack, o_wb_err, o_wb_rty, o_wb_dat} !== {3'b001, 32'h0})
      $display("FAIL rd_rty: ack/err/rty=%b dat=%h want 001 0", {o_wb_ack, o_wb_err, o_wb_rty}, o_wb_dat);
    else n_pass++;
    tick();
    // done in the final allowed cycle beats the timeout
    start_xfer(1'b1, 24'h000004, 32'h4, 4'hF);
    repeat (254) tick();
    i_csr_done = 1'b1;
    tick();
    i_csr_done = 1'b0;
    n_total++;
    if ({o_wb_ack, o_wb_err} !== 2'b10)
      $display("FAIL done_at_expiry: ack/err=%b want 10", {o_wb_ack, o_wb_err});
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] acks;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_adr = 24'h000008; i_wb_sel = 4'h0;
    for (int c = 0; c < 4; c++) begin
      tick();
      acks[c] = o_wb_ack;
    end
    i_wb_stb = 1'b0;
    n_total++;
    if (acks !== 4'b0101)
      $display("FAIL b2b_acks: pattern=%b want 0101", acks);
    else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    logic req_held = 1'b1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b1;
    tick();
    i_wb_stb = 1'b0;
    n_total++;
    if ({o_wb_stall, o_csr_req} !== 2'b00)
      $display("FAIL stb_no_cyc: stall/req=%b want 00", {o_wb_stall, o_csr_req});
    else n_pass++;
    start_xfer(1'b1, 24'h000040, 32'h40, 4'hF);
    i_wb_cyc = 1'b0;
    repeat (3) begin
      tick();
      req_held &= o_csr_req;
    end
    i_csr_done = 1'b1;
    tick();
    i_csr_done = 1'b0;
    n_total++;
    if ({req_held, o_wb_ack, o_wb_err, o_wb_rty, o_csr_req, o_wb_stall} !== 6'b100001)
      $display("FAIL abort_resp: held/ack/err/rty/req/stall=%b want 100001",
               {req_held, o_wb_ack, o_wb_err, o_wb_rty, o_csr_req, o_wb_stall});
    else n_pass++;
    tick();
    n_total++;
    if ({o_wb_stall, o_wb_ack, o_wb_err, o_wb_rty} !== 4'b0000)
      $display("FAIL abort_idle: stall/ack/err/rty=%b want 0000",
               {o_wb_stall, o_wb_ack, o_wb_err, o_wb_rty});
    else n_pass++;
    // reset pulsed while waiting on the CSR
    start_xfer(1'b1, 24'h000055, 32'hCAFEF00D, 4'hF);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_wb_cyc = 1'b0;
    n_total++;
    if ({o_csr_req, o_wb_stall, o_wb_ack, o_wb_err, o_wb_rty, o_csr_we, o_csr_addr,
         o_csr_wdata, o_csr_wmask, o_wb_dat} !== 82'b0)
      $display("FAIL rst_mid: req=%b stall=%b addr=%h wdata=%h wmask=%h dat=%h want all 0",
               o_csr_req, o_wb_stall, o_csr_addr, o_csr_wdata, o_csr_wmask, o_wb_dat);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_ack();
    test_decode_err();
    test_timeout();
    test_priority();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
